not_response_checker_8bit: RTL and testbench
============================================

Name: not_response_checker_8bit

Overview:
- Response-side counterpart to the 8-bit NOT-gate stimulus driver. Consumes applied operand A and observed result Y, one vector per valid cycle, and checks Y == ~A.
- Counts mismatches, captures the first failing vector, and compacts all Y values into an 8-bit MISR signature.
- Sits beside not_gate_8bit as the synthesizable pass/fail analyser for ALU bring-up and BIST.

Parameters:
- VECTOR_COUNT, 4, number of vectors per run (1..255).
- MISR_SEED, 8'hFF, signature value loaded at start.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE.
- in_valid  input  1  a_in/y_in hold a vector this cycle.
- a_in  input  8  operand applied to the NOT gate.
- y_in  input  8  NOT-gate output observed.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the run completes.
- pass  output  1  high when the last completed run had zero mismatches; holds until next start/rst.
- err_count  output  8  mismatch count for the current/last run; saturates at 8'hFF.
- first_fail_a  output  8  a_in of the first mismatching vector.
- first_fail_y  output  8  y_in of the first mismatching vector.
- signature  output  8  MISR compaction of y_in.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, pass=0, err_count=0, first_fail_a=0, first_fail_y=0, signature=0, internal vec_cnt=0. rst has priority over all other inputs and aborts a run in any state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN.
  - Same edge: err_count=0, first_fail_*=0, pass=0, signature=MISR_SEED, vec_cnt=0, internal first_seen=0.
  - in_valid is ignored in IDLE, including when it coincides with start.
- RUN (busy=1):
  - in_valid=0: all state holds.
  - in_valid=1: mismatch = (y_in != ~a_in).
    - On mismatch, err_count increments, saturating at FF.
    - On mismatch with first_seen=0, first_fail_a=a_in, first_fail_y=y_in, and first_seen is set.
  - On every valid vector, signature = ({sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00)) ^ y_in (polynomial x^8+x^4+x^3+x^2+1) and vec_cnt increments.
  - start is ignored in RUN.
- RUN -> DONE on the edge accepting the vector where vec_cnt == VECTOR_COUNT-1. pass is written at that same edge: 1 iff final err_count == 0, including the last vector.
- DONE: lasts exactly one cycle with done=1 and busy=0, then -> IDLE. start and in_valid are ignored in DONE.
- Result outputs (err_count, first_fail_*, signature, pass) hold their values in IDLE until the next accepted start or rst.
- Latency: results are final and done=1 in the cycle after the last valid vector is sampled.
- Back-to-back runs: start in the first IDLE cycle after DONE is accepted.
- Non-contiguous in_valid is allowed; only valid cycles count toward VECTOR_COUNT.

Test Plan:
- Golden run, VECTOR_COUNT=4: after start, drive (A,Y) = (00,FF), (FF,00), (A5,5A), (5A,A5) on consecutive valid cycles -> done pulses 1 cycle after the 4th vector; pass=1, err_count=0, first_fail_a/y=00/00, signature=8'hF1 (intermediate values 1C, 38, 2A, F1).
- Single fault: same run with the third vector as (A5,5B) -> pass=0, err_count=1, first_fail_a=A5, first_fail_y=5B, done on the same cycle as the golden run.
- Multiple faults with gaps: vectors (00,00), idle 2 cycles, (FF,FF), (A5,5A), (5A,A5) -> err_count=2, first_fail_a=00, first_fail_y=00 (the second fault does not overwrite), done 1 cycle after the 4th valid vector.
- Protocol ignores:
  - in_valid=1 with start=1 in IDLE -> vector not counted; 4 further vectors are still required for done.
  - start pulsed mid-RUN -> no effect on counters or signature.
  - in_valid during the DONE cycle -> ignored.
- Reset mid-run: rst=1 after 2 vectors -> next cycle busy=0, all outputs 0, no done pulse. A following start plus the golden run gives pass=1 and signature=F1.
- Back-to-back: start in the cycle after the done pulse -> second golden run yields an identical signature=F1; pass reads 0 between the second start and the second done.

Source files
------------

// File: rtl/not_response_checker_8bit.sv
// Response checker for the 8-bit NOT gate: verifies y_in == ~a_in per valid vector,
// counts mismatches, captures the first failing vector and compacts y_in into a MISR.
module not_response_checker_8bit #(
  parameter int unsigned VECTOR_COUNT = 4,
  parameter logic [7:0]  MISR_SEED    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] a_in,
  input  logic [7:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_fail_a,
  output logic [7:0] first_fail_y,
  output logic [7:0] signature
);

  localparam int unsigned W = 8;
  localparam logic [W-1:0] LAST_IDX = W'(VECTOR_COUNT - 1);
  localparam logic [W-1:0] MISR_POLY = 8'h1D;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state, state_nxt;
  logic [W-1:0] vec_cnt, vec_cnt_nxt;
  logic         first_seen, first_seen_nxt;
  logic         pass_nxt;
  logic [W-1:0] err_count_nxt, first_fail_a_nxt, first_fail_y_nxt, signature_nxt;
  logic         mismatch_c;

  // One MISR step: shift left, fold feedback x^8+x^4+x^3+x^2+1, then mix in data
  function automatic logic [W-1:0] misr_step(input logic [W-1:0] sig, input logic [W-1:0] data);
    misr_step = ({sig[W-2:0], 1'b0} ^ (sig[W-1] ? MISR_POLY : '0)) ^ data;
  endfunction

  assign mismatch_c = (y_in != ~a_in);

  // Next-state and next-result logic
  always_comb begin
    state_nxt        = state;
    vec_cnt_nxt      = vec_cnt;
    first_seen_nxt   = first_seen;
    pass_nxt         = pass;
    err_count_nxt    = err_count;
    first_fail_a_nxt = first_fail_a;
    first_fail_y_nxt = first_fail_y;
    signature_nxt    = signature;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt        = RUN;
          vec_cnt_nxt      = '0;
          first_seen_nxt   = 1'b0;
          pass_nxt         = 1'b0;
          err_count_nxt    = '0;
          first_fail_a_nxt = '0;
          first_fail_y_nxt = '0;
          signature_nxt    = MISR_SEED;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (mismatch_c) begin
            if (err_count != 8'hFF) err_count_nxt = err_count + W'(1);
            if (!first_seen) begin
              first_fail_a_nxt = a_in;
              first_fail_y_nxt = y_in;
              first_seen_nxt   = 1'b1;
            end
          end
          signature_nxt = misr_step(signature, y_in);
          vec_cnt_nxt   = vec_cnt + W'(1);
          if (vec_cnt == LAST_IDX) begin
            state_nxt = DONE;
            pass_nxt  = (err_count_nxt == '0);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; busy/done follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vec_cnt      <= '0;
      first_seen   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_fail_a <= '0;
      first_fail_y <= '0;
      signature    <= '0;
    end else begin
      state        <= state_nxt;
      vec_cnt      <= vec_cnt_nxt;
      first_seen   <= first_seen_nxt;
      busy         <= (state_nxt == RUN);
      done         <= (state_nxt == DONE);
      pass         <= pass_nxt;
      err_count    <= err_count_nxt;
      first_fail_a <= first_fail_a_nxt;
      first_fail_y <= first_fail_y_nxt;
      signature    <= signature_nxt;
    end
  end

endmodule

// File: tb/tb_not_response_checker_8bit.sv
// Directed bench for not_response_checker_8bit with hand-computed MISR and result values.
module tb_not_response_checker_8bit;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] a_in, y_in;
  logic       busy, done, pass;
  logic [7:0] err_count, first_fail_a, first_fail_y, signature;

  int n_cmp = 0;
  int n_bad = 0;

  not_response_checker_8bit #(.VECTOR_COUNT(4), .MISR_SEED(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a_in(a_in), .y_in(y_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_a(first_fail_a),
    .first_fail_y(first_fail_y), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then settle just after it
  task automatic cyc(input logic r, input logic s, input logic v, input logic [7:0] a, input logic [7:0] y);
    rst = r; start = s; in_valid = v; a_in = a; y_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input logic [7:0] a, input logic [7:0] y);
    cyc(1'b0, 1'b0, 1'b1, a, y);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_results(input string tag, input logic p, input logic [7:0] ec,
                               input logic [7:0] fa, input logic [7:0] fy, input logic [7:0] sg);
    check({tag, "_pass"}, 8'(pass), 8'(p));
    check({tag, "_err"}, err_count, ec);
    check({tag, "_ffa"}, first_fail_a, fa);
    check({tag, "_ffy"}, first_fail_y, fy);
    check({tag, "_sig"}, signature, sg);
  endtask

  // Start plus the four golden vectors with intermediate signature checks
  task automatic golden_run(input string tag);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    check({tag, "_busy"}, 8'(busy), 8'h01);
    check({tag, "_pass_start"}, 8'(pass), 8'h00);
    check({tag, "_seed"}, signature, 8'hFF);
    vec(8'h00, 8'hFF); check({tag, "_sig1"}, signature, 8'h1C);
    vec(8'hFF, 8'h00); check({tag, "_sig2"}, signature, 8'h38);
    vec(8'hA5, 8'h5A); check({tag, "_sig3"}, signature, 8'h2A);
    check({tag, "_nodone3"}, 8'(done), 8'h00);
    check({tag, "_pass_mid"}, 8'(pass), 8'h00);
    vec(8'h5A, 8'hA5);
    check({tag, "_done"}, 8'(done), 8'h01);
    check({tag, "_busy_done"}, 8'(busy), 8'h00);
    check_results(tag, 1'b1, 8'h00, 8'h00, 8'h00, 8'hF1);
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_done", 8'(done), 8'h00);
    check_results("rst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    idle();

    // Golden run, then results hold in IDLE
    golden_run("gold");
    idle();
    check("gold_done_pulse", 8'(done), 8'h00);
    idle();
    check_results("gold_hold", 1'b1, 8'h00, 8'h00, 8'h00, 8'hF1);

    // Single fault on third vector
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vec(8'h00, 8'hFF);
    vec(8'hFF, 8'h00);
    vec(8'hA5, 8'h5B);
    check("sf_err3", err_count, 8'h01);
    vec(8'h5A, 8'hA5);
    check("sf_done", 8'(done), 8'h01);
    check_results("sf", 1'b0, 8'h01, 8'hA5, 8'h5B, 8'hF3);
    idle();

    // Two faults with an idle gap; first fail must not be overwritten
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vec(8'h00, 8'h00);
    idle(); idle();
    check("mf_busy_gap", 8'(busy), 8'h01);
    check("mf_sig_gap", signature, 8'hE3);
    vec(8'hFF, 8'hFF);
    vec(8'hA5, 8'h5A);
    check("mf_nodone", 8'(done), 8'h00);
    vec(8'h5A, 8'hA5);
    check("mf_done", 8'(done), 8'h01);
    check_results("mf", 1'b0, 8'h02, 8'h00, 8'h00, 8'h81);
    idle();

    // in_valid with start ignored; start mid-run ignored; in_valid in DONE ignored
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    check("ign_sig_start", signature, 8'hFF);
    check("ign_err_start", err_count, 8'h00);
    vec(8'h00, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
    check("ign_sig_midstart", signature, 8'h38);
    vec(8'hA5, 8'h5A);
    check("ign_nodone", 8'(done), 8'h00);
    vec(8'h5A, 8'hA5);
    check("ign_done", 8'(done), 8'h01);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    check("ign_idle_busy", 8'(busy), 8'h00);
    check_results("ign", 1'b1, 8'h00, 8'h00, 8'h00, 8'hF1);
    idle();

    // Reset mid-run aborts, then a clean golden run
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    vec(8'h00, 8'h00);
    vec(8'hFF, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'hA5, 8'h5A);
    check("mrst_busy", 8'(busy), 8'h00);
    check("mrst_done", 8'(done), 8'h00);
    check_results("mrst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    vec(8'h5A, 8'hA5);
    check("mrst_nodone", 8'(done), 8'h00);
    check("mrst_still_idle", 8'(busy), 8'h00);
    golden_run("mrst_gold");

    // Back-to-back: start in first IDLE cycle after done
    idle();
    golden_run("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
